uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller between uart_rx and the byte consumer. Detects each
//  completed frame (rising edge of uart_rx's rx_ready) and captures the byte.
//  Buffers captured bytes in a DEPTH-entry FIFO and presents them on a
//  valid/ready stream. Tracks overrun and, optionally, an inter-byte idle timeout.
// PARAMETERS
//  DEPTH          8   FIFO entries; power of 2, >= 2
//  TIMEOUT_TICKS  40  baud_tick count with no new byte before timeout asserts; >= 1
// PORTS
//  clk          in   1               system clock
//  rst          in   1               reset, asynchronous, active-high
//  baud_tick    in   1               shared baud strobe, same source as uart_rx
//  rx_ready     in   1               uart_rx frame-complete level
//  rx_data      in   8               uart_rx shift_reg, stable while rx_ready=1
//  enable       in   1               1 = capture frames; 0 = ignore new frames
//  flush        in   1               synchronous FIFO clear, 1-cycle pulse
//  m_data       out  8               FIFO head byte, show-ahead
//  m_valid      out  1               FIFO not empty
//  m_ready      in   1               consumer accepts m_data when m_valid=1
//  fifo_count   out  $clog2(DEPTH)+1 bytes held, 0..DEPTH
//  overrun      out  1               sticky: a byte was dropped because FIFO full
//  overrun_clr  in   1               clears overrun
//  timeout      out  1               idle timeout; only under macro, else tied 0
// BEHAVIOUR
//  Reset values: m_valid=0, fifo_count=0, overrun=0, timeout=0, m_data=8'h00,
//   rd/wr pointers=0, rx_ready_q=0, idle counter=0.
//  Edge detect: rx_ready_q <= rx_ready every clk.
//   capture = rx_ready & ~rx_ready_q & enable. rx_ready held high captures once.
//  enable rising while rx_ready is already high does not capture the stale byte.
//  Push: on capture, mem[wr_ptr] <= rx_data and wr_ptr++.
//   Accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
//  Full drop: on capture with fifo_count==DEPTH and no pop, the byte is discarded
//   and overrun <= 1. FIFO contents are unchanged.
//  Pop: when m_valid & m_ready, rd_ptr++.
//  Latency: byte written at the edge where capture=1; m_valid=1 and m_data valid
//   from the next cycle. m_data = mem[rd_ptr], combinational from the registered ptr.
//  Count: push only -> +1; pop only -> -1; push and pop together -> unchanged.
//  Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//  flush: highest priority. Pointers and count go to 0 and timeout clears.
//   A capture or pop in the same cycle is discarded. flush does NOT clear overrun.
//  overrun: set has priority over overrun_clr in the same cycle.
//  m_data when m_valid=0 is don't-care; the bench must not check it.
//  Async rst mid-frame: all state is cleared. A later rising edge of rx_ready
//   is captured normally.
// CONFIGURATION
//  Macro UART_RX_CTRL_TIMEOUT_EN.
//  Defined: idle_cnt (width $clog2(TIMEOUT_TICKS+1)) with states
//   IDLE (fifo empty) -> COUNT (fifo non-empty) -> EXPIRED.
//   - IDLE -> COUNT on a push into an empty FIFO; idle_cnt=0.
//   - In COUNT, each baud_tick increments idle_cnt.
//   - COUNT -> EXPIRED when idle_cnt reaches TIMEOUT_TICKS; timeout=1 (registered).
//   - A push in COUNT or EXPIRED resets idle_cnt=0, returns to COUNT, timeout=0.
//   - FIFO becoming empty, or flush, returns to IDLE with timeout=0.
//   - idle_cnt saturates at TIMEOUT_TICKS.
//  Undefined: timeout is constant 0 and no counter logic is built.
//   All other behaviour is identical.
// TESTING
//  1 Single byte: drive rx_data=8'hA5 and raise rx_ready for 3 cycles.
//    -> m_valid=1 the next cycle, m_data=A5, fifo_count=1.
//    -> Pulse m_ready -> fifo_count=0 and m_valid=0.
//  2 Burst fill: 8 rising edges with bytes 01..08 and m_ready=0.
//    -> fifo_count=8, overrun=0.
//    -> 9th byte 09: fifo_count stays 8, overrun=1.
//    -> Draining reads 01..08 in order; byte 09 never appears.
//  3 Full, simultaneous push and pop: with count=8, capture 8'h55 in the same
//    cycle m_ready=1.
//    -> count stays 8, overrun stays 0, 55 is the last byte out.
//  4 Flush and clear priority: flush in the same cycle as a capture
//    -> count=0, byte lost.
//    overrun_clr in the same cycle as a new drop -> overrun stays 1.
//  5 enable=0 during a rising edge -> nothing captured.
//    enable asserted while rx_ready is high -> no capture until the next rising edge.
//  6 (UART_RX_CTRL_TIMEOUT_EN, TIMEOUT_TICKS=4): push 1 byte, hold m_ready=0.
//    -> timeout=1 after the 4th baud_tick.
//    -> A new push clears timeout; popping to empty clears timeout.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures uart_rx frames into a show-ahead FIFO on a valid/ready stream.
// Optional idle timeout built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DEPTH         = 8,
  parameter int TIMEOUT_TICKS = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   baud_tick,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   enable,
  input  logic                   flush,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rx_ready_q;
  logic          r_overrun;

  logic          w_capture;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  assign w_capture = rx_ready & ~r_rx_ready_q & enable & ~flush;
  assign w_pop     = (r_count != '0) & m_ready & ~flush;
  assign w_push    = w_capture & ((r_count != FULL) | w_pop);
  assign w_drop    = w_capture & (r_count == FULL) & ~w_pop;

  assign m_data     = r_mem[r_rd_ptr];
  assign m_valid    = (r_count != '0);
  assign fifo_count = r_count;
  assign overrun    = r_overrun;

  // next occupancy; flush wins over any push or pop
  always_comb begin
    w_count_nxt = r_count;
    if (flush)
      w_count_nxt = '0;
    else if (w_push & ~w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop & ~w_push)
      w_count_nxt = r_count - CW'(1);
  end

  // frame edge history, pointers, count and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ready_q <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_ready_q <= rx_ready;
      r_count      <= w_count_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop)
        r_overrun <= 1'b1;
      else if (overrun_clr)
        r_overrun <= 1'b0;
    end
  end

  // byte storage; cleared on reset so the head reads 8'h00
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_EXPIRED
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_idle_cnt;
  logic [TW-1:0] w_idle_nxt;
  logic          r_timeout;

  assign timeout = r_timeout;

  // timeout state register; timeout flag mirrors the EXPIRED state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_timeout  <= (w_state_nxt == S_EXPIRED);
    end
  end

  // idle tracking: flush > push > drained > tick counting
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_idle_nxt  = '0;
    end else if (w_push) begin
      w_state_nxt = S_COUNT;
      w_idle_nxt  = '0;
    end else if (w_count_nxt == '0) begin
      w_state_nxt = S_IDLE;
      w_idle_nxt  = '0;
    end else begin
      unique case (r_state)
        S_COUNT: begin
          if (baud_tick) begin
            if (r_idle_cnt >= TMAX - TW'(1)) begin
              w_idle_nxt  = TMAX;
              w_state_nxt = S_EXPIRED;
            end else begin
              w_idle_nxt = r_idle_cnt + TW'(1);
            end
          end
        end
        S_EXPIRED: w_idle_nxt = TMAX;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused = baud_tick ^ (TIMEOUT_TICKS == 0);
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed vectors for uart_rx_ctrl with hand-computed results.
// Timeout vectors run when UART_RX_CTRL_TIMEOUT_EN is defined.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       enable;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       overrun_clr;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  uart_rx_ctrl #(.DEPTH(8), .TIMEOUT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .enable(enable), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overrun(overrun),
    .overrun_clr(overrun_clr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic btick();
    baud_tick = 1'b1;
    tick();
    baud_tick = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; baud_tick = 0; rx_ready = 0; rx_data = 0;
    enable = 1; flush = 0; m_ready = 0; overrun_clr = 0;
    tick(); tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tmo", timeout, 0);
    rst = 1'b0;
    tick();

    // single byte, rx_ready held 3 cycles
    rx_data = 8'hA5; rx_ready = 1;
    tick();
    chk("t1_valid", m_valid, 1);
    chk("t1_data", m_data, 8'hA5);
    chk("t1_count", fifo_count, 1);
    tick(); tick();
    rx_ready = 0;
    tick();
    chk("t1_once", fifo_count, 1);
    m_ready = 1; tick(); m_ready = 0;
    chk("t1_pop_cnt", fifo_count, 0);
    chk("t1_pop_vld", m_valid, 0);

    // burst fill and drop
    for (int i = 1; i <= 8; i++) frame(8'(i));
    chk("t2_count", fifo_count, 8);
    chk("t2_ovr0", overrun, 0);
    frame(8'h09);
    chk("t2_cnt9", fifo_count, 8);
    chk("t2_ovr1", overrun, 1);
    m_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t2_drain%0d", i), m_data, i);
      tick();
    end
    m_ready = 0;
    chk("t2_empty", fifo_count, 0);
    overrun_clr = 1; tick(); overrun_clr = 0;
    chk("t2_clr", overrun, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i));
    rx_data = 8'h55; rx_ready = 1; m_ready = 1;
    tick();
    rx_ready = 0; m_ready = 0;
    tick();
    chk("t3_count", fifo_count, 8);
    chk("t3_ovr", overrun, 0);
    m_ready = 1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("t3_out%0d", i), m_data, 8'h10 + i);
      tick();
    end
    chk("t3_last", m_data, 8'h55);
    tick();
    m_ready = 0;
    chk("t3_empty", m_valid, 0);

    // flush beats a same-cycle capture
    rx_data = 8'h33; rx_ready = 1; flush = 1;
    tick();
    flush = 0; rx_ready = 0;
    tick();
    chk("t4_flcap", fifo_count, 0);
    frame(8'hAA);
    flush = 1; tick(); flush = 0;
    chk("t4_flush", fifo_count, 0);
    chk("t4_flvld", m_valid, 0);
    for (int i = 0; i < 9; i++) frame(8'h40 + 8'(i));
    chk("t4_ovr", overrun, 1);
    overrun_clr = 1; tick(); overrun_clr = 0;
    chk("t4_clr", overrun, 0);
    rx_data = 8'h66; rx_ready = 1; overrun_clr = 1;
    tick();
    rx_ready = 0; overrun_clr = 0;
    chk("t4_setwin", overrun, 1);
    chk("t4_cnt", fifo_count, 8);
    flush = 1; tick(); flush = 0;
    chk("t4_flkeep", overrun, 1);
    overrun_clr = 1; tick(); overrun_clr = 0;

    // enable gating
    enable = 0;
    rx_data = 8'h77; rx_ready = 1;
    tick();
    chk("t5_dis", fifo_count, 0);
    enable = 1;
    tick(); tick();
    chk("t5_stale", fifo_count, 0);
    rx_ready = 0; tick();
    rx_data = 8'h78; rx_ready = 1; tick();
    rx_ready = 0;
    chk("t5_cnt", fifo_count, 1);
    chk("t5_data", m_data, 8'h78);
    tick();

    // async reset mid-frame
    rx_data = 8'h99; rx_ready = 1;
    @(negedge clk);
    rst = 1; #1;
    chk("ar_cnt", fifo_count, 0);
    chk("ar_vld", m_valid, 0);
    rx_ready = 0;
    tick();
    rst = 0;
    tick();
    frame(8'h5A);
    chk("ar_cap", fifo_count, 1);
    chk("ar_data", m_data, 8'h5A);
    m_ready = 1; tick(); m_ready = 0;

    // idle timeout
    frame(8'hC1);
    for (int i = 0; i < 3; i++) btick();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    chk("t6_pre", timeout, 0);
    btick();
    chk("t6_set", timeout, 1);
    frame(8'hC2);
    chk("t6_push", timeout, 0);
    for (int i = 0; i < 4; i++) btick();
    chk("t6_set2", timeout, 1);
    m_ready = 1; tick();
    chk("t6_hold", timeout, 1);
    tick(); m_ready = 0;
    chk("t6_empty", timeout, 0);
`else
    btick(); btick();
    chk("t6_off", timeout, 0);
    m_ready = 1; tick(); m_ready = 0;
    chk("t6_offcnt", fifo_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
